pc_word_fetch: RTL and testbench

Instruction-fetch address unit for the pipeline front end. It holds the byte-addressed program counter, accepts byte-addressed redirect targets from the branch/jump path, converts byte addresses to word indices for the word-organised instruction memory (drops bits [1:0]), and issues fetch requests with a ready handshake. Misaligned targets are trapped and reported, and responses made stale by a redirect are squashed. It sits between the branch-target logic and the instruction memory, and performs the byte-to-word direction of the word-to-byte offset scaling used by the branch path.

---
 rtl/pc_word_fetch.sv | 107 ++++++++++
 tb/tb_pc_word_fetch.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pc_word_fetch.sv
// Instruction-fetch address unit: byte PC, redirects, word-indexed fetch requests with ready handshake.
// Optional define FETCH_RANGE_CHECK_EN traps targets and sequential PCs beyond the 2^IMEM_AW-word memory.
module pc_word_fetch #(
  parameter int unsigned IMEM_AW  = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_addr,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ready,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               fetch_valid,
  output logic [31:0]        fetch_pc,
  output logic               fault,
  output logic [31:0]        fault_addr
);

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_d, fetch_pc_d, fault_addr_d;
  logic        fault_d;
  logic        issued_q, issued_d;
  logic        squash_q, squash_d;
  logic        accept;
  logic        redirect_bad;

`ifdef FETCH_RANGE_CHECK_EN
  function automatic logic out_of_range(input logic [31:0] a);
    return (a >> (IMEM_AW + 2)) != 32'd0;
  endfunction

  assign redirect_bad = (|redirect_addr[1:0]) | out_of_range(redirect_addr);
`else
  assign redirect_bad = |redirect_addr[1:0];
`endif

  assign pc_plus4    = pc + 32'd4;
  assign imem_addr   = pc[IMEM_AW+1:2];
  assign imem_req    = (state_q == RUN) & ~stall & ~redirect_valid;
  assign accept      = imem_req & imem_ready;
  // A response whose request overlapped a redirect is dropped on return.
  assign fetch_valid = issued_q & ~squash_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc;
    fault_d      = fault;
    fault_addr_d = fault_addr;
    fetch_pc_d   = fetch_pc;
    issued_d     = accept;
    squash_d     = accept & redirect_valid;

    if (accept) begin
      fetch_pc_d = pc;
    end

    if (redirect_valid) begin
      if (redirect_bad) begin
        state_d      = FAULT;
        fault_d      = 1'b1;
        fault_addr_d = redirect_addr;
      end else begin
        state_d = RUN;
        fault_d = 1'b0;
        pc_d    = redirect_addr;
      end
    end else if (stall) begin
      pc_d = pc;
    end else if (accept) begin
      pc_d = pc_plus4;
`ifdef FETCH_RANGE_CHECK_EN
      if (out_of_range(pc_plus4)) begin
        state_d      = FAULT;
        fault_d      = 1'b1;
        fault_addr_d = pc_plus4;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= RUN;
      pc         <= RESET_PC;
      fetch_pc   <= 32'd0;
      fault      <= 1'b0;
      fault_addr <= 32'd0;
      issued_q   <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc         <= pc_d;
      fetch_pc   <= fetch_pc_d;
      fault      <= fault_d;
      fault_addr <= fault_addr_d;
      issued_q   <= issued_d;
      squash_q   <= squash_d;
    end
  end

endmodule

// File: tb/tb_pc_word_fetch.sv
// Bench for pc_word_fetch: behavioural PC model plus a scoreboard of accepted fetch addresses.
module tb_pc_word_fetch;

  localparam int unsigned IMEM_AW  = 10;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic               clk = 1'b0;
  logic               reset_n, stall, redirect_valid, imem_ready;
  logic [31:0]        redirect_addr;
  logic               imem_req, fetch_valid, fault;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        pc, pc_plus4, fetch_pc, fault_addr;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb[$];
  logic        m_known = 1'b0;
  logic        m_run;
  logic [31:0] m_pc, m_fault_addr;
  logic        m_fault;

  pc_word_fetch #(.IMEM_AW(IMEM_AW), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fault(fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_oor(input logic [31:0] a);
`ifdef FETCH_RANGE_CHECK_EN
    return (a >> (IMEM_AW + 2)) != 32'd0;
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: check last edge's response, drive inputs, check state, predict next edge.
  task automatic cycle(input logic rn, input logic s, input logic rv,
                       input logic [31:0] ra, input logic rdy);
    logic        req, acc;
    logic [31:0] e;
    if (m_known) begin
      check("fetch_valid", 32'(fetch_valid), 32'(sb.size() > 0));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("fetch_pc", fetch_pc, e);
      end
    end
    reset_n = rn; stall = s; redirect_valid = rv; redirect_addr = ra; imem_ready = rdy;
    #1;
    req = m_run & ~s & ~rv;
    acc = req & rdy;
    if (m_known) begin
      check("imem_req", 32'(imem_req), 32'(req));
      check("imem_addr", 32'(imem_addr), 32'(m_pc[IMEM_AW+1:2]));
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("fault", 32'(fault), 32'(m_fault));
      check("fault_addr", fault_addr, m_fault_addr);
    end
    @(posedge clk);
    if (!rn) begin
      m_known = 1'b1; m_run = 1'b1; m_pc = RESET_PC;
      m_fault = 1'b0; m_fault_addr = 32'd0;
      sb.delete();
    end else if (m_known) begin
      if (acc && !rv) sb.push_back(m_pc);
      if (rv) begin
        if ((ra[1:0] != 2'b00) || m_oor(ra)) begin
          m_run = 1'b0; m_fault = 1'b1; m_fault_addr = ra;
        end else begin
          m_run = 1'b1; m_fault = 1'b0; m_pc = ra;
        end
      end else if (!s && acc) begin
        m_pc = m_pc + 32'd4;
        if (m_oor(m_pc)) begin
          m_run = 1'b0; m_fault = 1'b1; m_fault_addr = m_pc;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, rdy);
  endtask

  task automatic redir(input logic s, input logic [31:0] a);
    cycle(1'b1, s, 1'b1, a, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_addr = 32'd0; imem_ready = 1'b1;
    @(negedge clk);

    // reset, then sequential fetch 0x0, 0x4, 0x8, 0xC
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check("reset_pc", pc, RESET_PC);
    run(4, 1'b1);
    check("pc_at_0x10", pc, 32'h10);

    // backpressure at 0x10
    run(3, 1'b0);
    check("held_imem_addr", 32'(imem_addr), 32'd4);
    run(2, 1'b1);

    // stall together with redirect: redirect wins
    redir(1'b1, 32'h100);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
    check("redir_pc", pc, 32'h100);
    run(3, 1'b1);

    // misaligned redirect, recover with aligned one
    redir(1'b0, 32'h102);
    run(1, 1'b1);
    check("fault_addr_102", fault_addr, 32'h102);
    run(2, 1'b1);
    redir(1'b0, 32'h200);
    run(3, 1'b1);

    // top of memory: range fault or index wrap depending on build
    redir(1'b0, 32'hFFC);
    run(3, 1'b1);
    redir(1'b0, 32'h1000);
    run(2, 1'b1);
    redir(1'b0, 32'hFFFF_FFFC);
    run(2, 1'b1);
    redir(1'b0, 32'h0);

    // reset in the cycle after an accept
    run(2, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    run(2, 1'b1);

    // random mix
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = {20'd0, 12'($urandom_range(0, 4095))};
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) a[31] = 1'b1;
      cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 7) == 0), a, ($urandom_range(0, 3) != 0));
    end
    run(2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
